// File: rtl/rotate_share_ctrl_pkg.sv
// Shared constants and op-code helpers for the rotate/shift controller.
package rotate_share_ctrl_pkg;

    localparam int DW = 32;
    localparam int AW = 5;

    localparam logic [2:0] OP_ROL = 3'd0;
    localparam logic [2:0] OP_ROR = 3'd1;
    localparam logic [2:0] OP_SLL = 3'd2;
    localparam logic [2:0] OP_SRL = 3'd3;
    localparam logic [2:0] OP_SRA = 3'd4;

    // Right-going ops reuse the left rotator with a negated amount.
    function automatic logic is_right_op(input logic [2:0] op);
        return (op == OP_ROR) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/left_rotator32.sv
// Combinational 32-bit left barrel rotator: five 2:1 mux stages (1,2,4,8,16).
module left_rotator32
    import rotate_share_ctrl_pkg::*;
(
    input  logic [DW-1:0] a,
    input  logic [AW-1:0] rot,
    output logic [DW-1:0] y
);

    logic [DW-1:0] s0, s1, s2, s3;

    assign s0 = rot[0] ? {a[DW-2:0],  a[DW-1]}         : a;
    assign s1 = rot[1] ? {s0[DW-3:0], s0[DW-1:DW-2]}   : s0;
    assign s2 = rot[2] ? {s1[DW-5:0], s1[DW-1:DW-4]}   : s1;
    assign s3 = rot[3] ? {s2[DW-9:0], s2[DW-1:DW-8]}   : s2;
    assign y  = rot[4] ? {s3[DW-17:0], s3[DW-1:DW-16]} : s3;

endmodule

// File: rtl/rotate_share_ctrl.sv
// Arbitrates two requesters onto one shared left rotator; shifts and right
// rotates are formed by amount remap plus masking. Result is registered.
module rotate_share_ctrl
    import rotate_share_ctrl_pkg::*;
#(
    parameter int RR_EN = 1,
    parameter int OPW   = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [DW-1:0]  req0_a,
    input  logic [AW-1:0]  req0_amt,
    input  logic [OPW-1:0] req0_op,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [DW-1:0]  req1_a,
    input  logic [AW-1:0]  req1_amt,
    input  logic [OPW-1:0] req1_op,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [DW-1:0]  out_data,
    output logic           out_id,
    output logic           out_err
);

    logic           ptr;
    logic           can_accept;
    logic           winner;
    logic           grant0;
    logic           grant1;
    logic           accept;
    logic [DW-1:0]  a_sel;
    logic [AW-1:0]  amt_sel;
    logic [OPW-1:0] op_sel;
    logic [2:0]     op3;
    logic [AW-1:0]  rot;
    logic [DW-1:0]  rotated;
    logic [DW-1:0]  result;
    logic           err;

    // Grant depends only on valids, pointer and output occupancy.
    always_comb begin
        can_accept = !out_valid || out_ready;
        winner     = (RR_EN != 0) ? ptr : 1'b0;
        grant0     = req0_valid && (!req1_valid || !winner);
        grant1     = req1_valid && (!req0_valid || winner);
        req0_ready = !reset && can_accept && grant0;
        req1_ready = !reset && can_accept && grant1;
        accept     = req0_ready || req1_ready;
    end

    always_comb begin
        a_sel   = grant1 ? req1_a   : req0_a;
        amt_sel = grant1 ? req1_amt : req0_amt;
        op_sel  = grant1 ? req1_op  : req0_op;
        op3     = 3'(op_sel);
        if (OPW > 3 && (op_sel >> 3) != '0) begin
            op3 = 3'b111;
        end
    end

    always_comb begin
        rot = amt_sel;
        if (is_right_op(op3)) begin
            rot = AW'(0) - amt_sel;
        end
    end

    left_rotator32 u_rot (
        .a   (a_sel),
        .rot (rot),
        .y   (rotated)
    );

    // Shifts mask off the bits that wrapped around; SRA back-fills with sign.
    always_comb begin
        result = a_sel;
        err    = 1'b0;
        case (op3)
            OP_ROL, OP_ROR: result = rotated;
            OP_SLL:         result = rotated & ({DW{1'b1}} << amt_sel);
            OP_SRL:         result = rotated & ({DW{1'b1}} >> amt_sel);
            OP_SRA:         result = (rotated & ({DW{1'b1}} >> amt_sel))
                                   | (~({DW{1'b1}} >> amt_sel) & {DW{a_sel[DW-1]}});
            default: begin
                result = a_sel;
                err    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= 1'b0;
            out_err   <= 1'b0;
            ptr       <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= result;
            out_id    <= grant1;
            out_err   <= err;
            if (RR_EN != 0) begin
                ptr <= !grant1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rotate_share_ctrl.sv
// Bench: round-robin and fixed-priority instances share stimulus; a cycle model
// predicts grants and a scoreboard checks every consumed result.
module tb_rotate_share_ctrl;
    import rotate_share_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        v0, v1, ordy;
    logic [31:0] a0, a1;
    logic [4:0]  m0, m1;
    logic [2:0]  o0, o1;

    logic        r0_rr, r1_rr, ov_rr, id_rr, er_rr;
    logic [31:0] d_rr;
    logic        r0_fp, r1_fp, ov_fp, id_fp, er_fp;
    logic [31:0] d_fp;

    rotate_share_ctrl #(.RR_EN(1), .OPW(3)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(v0), .req0_ready(r0_rr), .req0_a(a0), .req0_amt(m0), .req0_op(o0),
        .req1_valid(v1), .req1_ready(r1_rr), .req1_a(a1), .req1_amt(m1), .req1_op(o1),
        .out_valid(ov_rr), .out_ready(ordy), .out_data(d_rr), .out_id(id_rr), .out_err(er_rr)
    );

    rotate_share_ctrl #(.RR_EN(0), .OPW(3)) dut_fp (
        .clk(clk), .reset(reset),
        .req0_valid(v0), .req0_ready(r0_fp), .req0_a(a0), .req0_amt(m0), .req0_op(o0),
        .req1_valid(v1), .req1_ready(r1_fp), .req1_a(a1), .req1_amt(m1), .req1_op(o1),
        .out_valid(ov_fp), .out_ready(ordy), .out_data(d_fp), .out_id(id_fp), .out_err(er_fp)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        id;
        logic        err;
    } exp_t;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [4:0]  amt;
        logic [31:0] exp;
        logic        err;
    } vec_t;

    exp_t q_rr[$];
    exp_t q_fp[$];
    exp_t e0, e1;
    vec_t tbl[17];
    int   checks = 0;
    int   errors = 0;
    logic mptr[2];
    logic mval[2];
    logic s_r0, s_r1, s_ov, s_id, s_r0f, s_r1f;
    logic [31:0] s_d;

    function automatic logic [32:0] ref_op(input logic [31:0] a, input logic [4:0] amt,
                                           input logic [2:0] op);
        logic [63:0]        d;
        logic signed [31:0] s;
        d = {a, a};
        s = a;
        case (op)
            3'd0: begin d = d >> (32 - int'(amt)); return {1'b0, d[31:0]}; end
            3'd1: begin d = d >> amt;              return {1'b0, d[31:0]}; end
            3'd2: return {1'b0, a << amt};
            3'd3: return {1'b0, a >> amt};
            3'd4: return {1'b0, 32'(s >>> amt)};
            default: return {1'b1, a};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int k, input logic v, input logic [31:0] a,
                         input logic [4:0] amt, input logic [2:0] op);
        logic [32:0] r;
        r = ref_op(a, amt, op);
        if (k == 0) begin
            v0 = v; a0 = a; m0 = amt; o0 = op;
            e0 = '{data: r[31:0], id: 1'b0, err: r[32]};
        end else begin
            v1 = v; a1 = a; m1 = amt; o1 = op;
            e1 = '{data: r[31:0], id: 1'b1, err: r[32]};
        end
    endtask

    task automatic observe(input int k, input logic r0, input logic r1, input logic ov,
                           input logic [31:0] od, input logic oid, input logic oerr);
        logic can, win, g0, g1;
        exp_t exp;
        if (reset) begin
            chk("ready0_in_reset", r0, 1'b0);
            chk("ready1_in_reset", r1, 1'b0);
            if (k == 0) q_rr.delete(); else q_fp.delete();
            mval[k] = 1'b0;
            mptr[k] = 1'b0;
            return;
        end
        chk("out_valid", ov, mval[k]);
        can = !mval[k] || ordy;
        win = (k == 0) ? mptr[k] : 1'b0;
        g0  = can && v0 && (!v1 || !win);
        g1  = can && v1 && (!v0 || win);
        chk("req0_ready", r0, g0);
        chk("req1_ready", r1, g1);
        if (ov && ordy) begin
            if ((k == 0 && q_rr.size() == 0) || (k == 1 && q_fp.size() == 0)) begin
                chk("scoreboard_underflow", 32'd1, 32'd0);
            end else begin
                exp = (k == 0) ? q_rr.pop_front() : q_fp.pop_front();
                chk("out_data", od, exp.data);
                chk("out_id", oid, exp.id);
                chk("out_err", oerr, exp.err);
            end
        end
        if (g0) begin
            if (k == 0) q_rr.push_back(e0); else q_fp.push_back(e0);
        end
        if (g1) begin
            if (k == 0) q_rr.push_back(e1); else q_fp.push_back(e1);
        end
        if (g0 || g1) begin
            mval[k] = 1'b1;
            mptr[k] = !g1;
        end else if (ordy) begin
            mval[k] = 1'b0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        s_r0 = r0_rr; s_r1 = r1_rr; s_ov = ov_rr; s_id = id_rr; s_d = d_rr;
        s_r0f = r0_fp; s_r1f = r1_fp;
        observe(0, r0_rr, r1_rr, ov_rr, d_rr, id_rr, er_rr);
        observe(1, r0_fp, r1_fp, ov_fp, d_fp, id_fp, er_fp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] held;
        tbl[0]  = '{OP_ROL, 32'h80000001, 5'd1,  32'h00000003, 1'b0};
        tbl[1]  = '{OP_ROR, 32'h00000001, 5'd4,  32'h10000000, 1'b0};
        tbl[2]  = '{OP_SRA, 32'h80000000, 5'd31, 32'hFFFFFFFF, 1'b0};
        tbl[3]  = '{OP_SRL, 32'h80000000, 5'd31, 32'h00000001, 1'b0};
        tbl[4]  = '{3'b110, 32'hDEADBEEF, 5'd5,  32'hDEADBEEF, 1'b1};
        tbl[5]  = '{OP_SLL, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 1'b0};
        tbl[6]  = '{OP_SLL, 32'h12345679, 5'd31, 32'h80000000, 1'b0};
        tbl[7]  = '{OP_ROL, 32'h12345678, 5'd8,  32'h34567812, 1'b0};
        tbl[8]  = '{OP_ROR, 32'h12345678, 5'd8,  32'h78123456, 1'b0};
        tbl[9]  = '{OP_SRA, 32'h7FFFFFF0, 5'd4,  32'h07FFFFFF, 1'b0};
        tbl[10] = '{OP_SRA, 32'hF0000000, 5'd4,  32'hFF000000, 1'b0};
        tbl[11] = '{OP_SRL, 32'hF0000000, 5'd4,  32'h0F000000, 1'b0};
        tbl[12] = '{OP_SLL, 32'h0000000F, 5'd4,  32'h000000F0, 1'b0};
        tbl[13] = '{3'b101, 32'h00000000, 5'd9,  32'h00000000, 1'b1};
        tbl[14] = '{3'b111, 32'h55AA55AA, 5'd3,  32'h55AA55AA, 1'b1};
        tbl[15] = '{OP_ROR, 32'hCAFEBABE, 5'd0,  32'hCAFEBABE, 1'b0};
        tbl[16] = '{OP_SRA, 32'h80000000, 5'd0,  32'h80000000, 1'b0};

        reset = 1'b1; ordy = 1'b1;
        drive(0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, '0, '0, '0);
        @(posedge clk); #1;
        step();
        reset = 1'b0;
        chk("reset_out_valid", ov_rr, 1'b0);
        chk("reset_out_data", d_rr, 32'h0);
        chk("reset_out_id", id_rr, 1'b0);
        chk("reset_out_err", er_rr, 1'b0);

        // Table: one request per cycle, alternating requesters.
        for (int i = 0; i < 17; i++) begin
            drive(i % 2, 1'b1, tbl[i].a, tbl[i].amt, tbl[i].op);
            drive((i + 1) % 2, 1'b0, '0, '0, '0);
            if (i % 2 == 0) e0 = '{data: tbl[i].exp, id: 1'b0, err: tbl[i].err};
            else            e1 = '{data: tbl[i].exp, id: 1'b1, err: tbl[i].err};
            step();
            chk("tbl_accept", (i % 2 == 0) ? s_r0 : s_r1, 1'b1);
        end
        drive(0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, '0, '0, '0);
        step();
        step();

        // Contention after reset: RR alternates 0,1,0,1; fixed priority stays on 0.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(0, 1'b1, 32'h00000100 + i, 5'(i), OP_ROL);
            drive(1, 1'b1, 32'h00A00000 + i, 5'(i + 1), OP_SRL);
            step();
            chk("rr_grant0", s_r0, (i % 2 == 0) ? 1'b1 : 1'b0);
            chk("rr_grant1", s_r1, (i % 2 == 1) ? 1'b1 : 1'b0);
            chk("fp_grant0", s_r0f, 1'b1);
            chk("fp_grant1", s_r1f, 1'b0);
            if (i > 0) chk("rr_out_id_lag", s_id, (i % 2 == 1) ? 1'b0 : 1'b1);
        end

        // Backpressure with both requesters pending.
        ordy = 1'b0;
        step();
        held = s_d;
        chk("stall_ready0", s_r0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("stall_data_stable", s_d, held);
            chk("stall_ready1", s_r1, 1'b0);
        end
        ordy = 1'b1;
        step();
        chk("release_accept", s_r0 | s_r1, 1'b1);
        step();
        chk("release_out_valid", s_ov, 1'b1);

        // Reset while a result is stalled; first grant afterwards goes to req0.
        ordy = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        ordy = 1'b1;
        step();
        chk("post_reset_out_valid", s_ov, 1'b0);
        chk("post_reset_grant0", s_r0, 1'b1);
        chk("post_reset_grant1", s_r1, 1'b0);

        drive(0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, '0, '0, '0);
        step();
        step();
        chk("drain_rr", 32'(q_rr.size()), 32'd0);
        chk("drain_fp", 32'(q_fp.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
